// File: rtl/stream_integrity_checker.sv
// Stream integrity checker: seeds an expected-data generator from the first source word,
// then compares every returned word. Define CHECK_LATENCY_EN to add the first-word latency counter.
module stream_integrity_checker #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned MODE    = 0,
    parameter logic [31:0] POLY    = 32'h8020_0003,
    parameter logic [31:0] LAT_MAX = 32'd100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act,
    output logic [4:0]        error,
    output logic [1:0]        state
`ifdef CHECK_LATENCY_EN
    ,
    output logic [31:0]       latency
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d, exp_next;
    logic [DATA_W-1:0] first_exp_q, first_exp_d;
    logic [DATA_W-1:0] first_act_q, first_act_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [4:0]        error_q, error_d;
`ifdef CHECK_LATENCY_EN
    logic [31:0]       lat_q, lat_d;
`endif

    if (MODE == 0) begin : g_inc
        assign exp_next = exp_q + DATA_W'(1);
    end else begin : g_lfsr
        localparam logic [DATA_W-1:0] POLY_W = DATA_W'(POLY);
        assign exp_next = {exp_q[DATA_W-2:0], 1'b0} ^ (exp_q[DATA_W-1] ? POLY_W : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            first_exp_q <= '0;
            first_act_q <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            outst_q     <= '0;
            error_q     <= '0;
`ifdef CHECK_LATENCY_EN
            lat_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            outst_q     <= outst_d;
            error_q     <= error_d;
`ifdef CHECK_LATENCY_EN
            lat_q       <= lat_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_data_valid) state_d = ARMED;
            ARMED:   if (rd_data_valid) state_d = CHECK;
            CHECK:   state_d = CHECK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exp_d       = exp_q;
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        outst_d     = outst_q;
        error_d     = error_q;
        if (state_q == IDLE) begin
            if (wr_data_valid) begin
                exp_d   = wr_data;
                outst_d = CNT_W'(1);
            end
            if (rd_data_valid) error_d[1] = 1'b1;
        end else begin
            case ({wr_data_valid, rd_data_valid})
                2'b10: outst_d = outst_q + CNT_W'(1);
                2'b01: begin
                    if (outst_q == '0) error_d[2] = 1'b1;
                    else               outst_d = outst_q - CNT_W'(1);
                end
                default: ;
            endcase
            if (rd_data_valid) begin
                exp_d      = exp_next;
                word_cnt_d = word_cnt_q + CNT_W'(1);
                if (rd_data != exp_q) begin
                    error_d[0] = 1'b1;
                    // err_cnt saturates, so zero means no mismatch seen since reset
                    if (err_cnt_q == '0) begin
                        first_exp_d = exp_q;
                        first_act_d = rd_data;
                    end
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                    if (err_cnt_d == '1) error_d[3] = 1'b1;
                end
            end
        end
`ifdef CHECK_LATENCY_EN
        lat_d = lat_q;
        if (state_q == ARMED && lat_q != '1) lat_d = lat_q + 32'd1;
        if (lat_d > LAT_MAX) error_d[4] = 1'b1;
`else
        error_d[4] = 1'b0;
`endif
    end

    assign word_cnt      = word_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_exp = first_exp_q;
    assign first_err_act = first_act_q;
    assign error         = error_q;
    assign state         = state_q;
`ifdef CHECK_LATENCY_EN
    assign latency       = lat_q;
`endif

endmodule

// File: tb/tb_stream_integrity_checker.sv
// Directed bench for stream_integrity_checker: increment, LFSR and narrow-counter instances
// share one stimulus bus; each test checks only the instance it targets.
module tb_stream_integrity_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_data, rd_data;
    logic        wr_data_valid, rd_data_valid;

    logic [31:0] word_cnt0, err_cnt0, fexp0, fact0;
    logic [4:0]  error0;
    logic [1:0]  state0;
    logic [31:0] word_cnt1, err_cnt1, fexp1, fact1;
    logic [4:0]  error1;
    logic [1:0]  state1;
    logic [1:0]  word_cnt2, err_cnt2;
    logic [31:0] fexp2, fact2;
    logic [4:0]  error2;
    logic [1:0]  state2;
`ifdef CHECK_LATENCY_EN
    logic [31:0] latency0, latency1, latency2;
    localparam logic LAT_ON = 1'b1;
`else
    localparam logic LAT_ON = 1'b0;
`endif

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    stream_integrity_checker #(.MODE(0), .LAT_MAX(32'd10)) u_dut_inc (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .word_cnt(word_cnt0), .err_cnt(err_cnt0),
        .first_err_exp(fexp0), .first_err_act(fact0),
        .error(error0), .state(state0)
`ifdef CHECK_LATENCY_EN
        , .latency(latency0)
`endif
    );

    stream_integrity_checker #(.MODE(1)) u_dut_lfsr (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .word_cnt(word_cnt1), .err_cnt(err_cnt1),
        .first_err_exp(fexp1), .first_err_act(fact1),
        .error(error1), .state(state1)
`ifdef CHECK_LATENCY_EN
        , .latency(latency1)
`endif
    );

    stream_integrity_checker #(.MODE(0), .CNT_W(2)) u_dut_narrow (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .word_cnt(word_cnt2), .err_cnt(err_cnt2),
        .first_err_exp(fexp2), .first_err_act(fact2),
        .error(error2), .state(state2)
`ifdef CHECK_LATENCY_EN
        , .latency(latency2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic wv, input logic [31:0] wd, input logic rv, input logic [31:0] rdv);
        wr_data_valid = wv;
        wr_data       = wd;
        rd_data_valid = rv;
        rd_data       = rdv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b1, 32'hDEAD, 1'b1, 32'hBEEF);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] r;
        r = v << 1;
        if (v[31]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    initial begin
        logic [31:0] m, flip_exp;
        logic [31:0] rd_vec [7];
        rst = 1'b1;
        wr_data = '0; rd_data = '0; wr_data_valid = 1'b0; rd_data_valid = 1'b0;

        // reset state (inputs active during reset must be ignored)
        do_reset();
        check("rst_state", state0, 0);
        check("rst_word_cnt", word_cnt0, 0);
        check("rst_err_cnt", err_cnt0, 0);
        check("rst_error", error0, 0);
        check("rst_fexp", fexp0, 0);

        // 16 words 0x10..0x1F, returned 5 cycles later
        for (int c = 0; c < 21; c++) begin
            cycle(c < 16, 32'h10 + c, c >= 5, 32'h10 + c - 5);
            if (c == 0) check("armed_state", state0, 1);
            if (c == 5) begin
                check("first_beat_state", state0, 2);
                check("first_beat_cnt", word_cnt0, 1);
            end
        end
        check("inc16_word_cnt", word_cnt0, 16);
        check("inc16_err_cnt", err_cnt0, 0);
        check("inc16_error", error0, 0);
        check("inc16_state", state0, 2);
`ifdef CHECK_LATENCY_EN
        check("inc16_latency", latency0, 5);
`endif

        // mismatch on 4th word (7 for 3), later mismatch 9 for 6 must not overwrite capture
        do_reset();
        rd_vec = '{32'h0, 32'h1, 32'h2, 32'h7, 32'h4, 32'h5, 32'h9};
        cycle(1'b1, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 32'h0, 1'b1, rd_vec[i]);
            if (i == 3) check("mm_err_cnt_first", err_cnt0, 1);
        end
        check("mm_err_cnt", err_cnt0, 2);
        check("mm_word_cnt", word_cnt0, 7);
        check("mm_first_exp", fexp0, 32'h3);
        check("mm_first_act", fact0, 32'h7);
        check("mm_error", error0, 5'b00001);

        // rd before any wr, then normal traffic seeded by wr
        do_reset();
        cycle(1'b0, 32'h0, 1'b1, 32'h55);
        check("early_rd_error1", error0[1], 1);
        check("early_rd_word_cnt", word_cnt0, 0);
        check("early_rd_state", state0, 0);
        cycle(1'b1, 32'h20, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0, 1'b1, 32'h20 + i);
        check("early_rd_after_cnt", word_cnt0, 3);
        check("early_rd_after_err", err_cnt0, 0);
        check("early_rd_after_e0", error0[0], 0);

        // 3 wr, 4 rd: underflow on the 4th read only
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + i, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 32'h100 + i);
        check("uf_before_error", error0, 0);
        cycle(1'b0, 32'h0, 1'b1, 32'h103);
        check("uf_error", error0, 5'b00100);
        check("uf_word_cnt", word_cnt0, 4);
        check("uf_err_cnt", err_cnt0, 0);
`ifdef CHECK_LATENCY_EN
        check("uf_latency", latency0, 3);
`endif

        // simultaneous wr+rd with outstanding==0 is not an underflow
        do_reset();
        cycle(1'b1, 32'h5, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h5);
        cycle(1'b1, 32'h0, 1'b1, 32'h6);
        check("simul_error", error0, 0);
        check("simul_word_cnt", word_cnt0, 2);

        // late first read (20 cycles) against LAT_MAX=10, then mid-stream reset
        do_reset();
        cycle(1'b1, 32'h40, 1'b0, 32'h0);
        for (int i = 0; i < 19; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h40);
        check("lat_error4", error0[4], LAT_ON);
        check("lat_word_cnt", word_cnt0, 1);
`ifdef CHECK_LATENCY_EN
        check("lat_latency", latency0, 20);
`endif
        cycle(1'b1, 32'h0, 1'b1, 32'h99);
        do_reset();
        check("midrst_state", state0, 0);
        check("midrst_word_cnt", word_cnt0, 0);
        check("midrst_err_cnt", err_cnt0, 0);
        check("midrst_error", error0, 0);
        check("midrst_fexp", fexp0, 0);
        check("midrst_fact", fact0, 0);
`ifdef CHECK_LATENCY_EN
        check("midrst_latency", latency0, 0);
`endif
        cycle(1'b1, 32'h80, 1'b0, 32'h0);
        cycle(1'b1, 32'h0, 1'b1, 32'h80);
        cycle(1'b1, 32'h0, 1'b1, 32'h81);
        check("reseed_word_cnt", word_cnt0, 2);
        check("reseed_err_cnt", err_cnt0, 0);

        // narrow counters: err_cnt saturates at 3, word_cnt wraps mod 4
        do_reset();
        cycle(1'b1, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0, 1'b1, 32'hFF);
        check("sat_err_cnt", err_cnt2, 2'd3);
        check("sat_word_cnt", word_cnt2, 2'd1);
        check("sat_error", error2, 5'b01001);

        // LFSR loopback, 1000 words from seed 1
        do_reset();
        cycle(1'b1, 32'h1, 1'b0, 32'h0);
        m = 32'h1;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 32'h0, 1'b1, m);
            if (i == 32) check("lfsr_wrap_cnt", word_cnt1, 33);
            m = lfsr_step(m);
        end
        check("lfsr_word_cnt", word_cnt1, 1000);
        check("lfsr_err_cnt", err_cnt1, 0);
        check("lfsr_error", error1, 0);

        // same stream with bit 0 of word 500 flipped
        do_reset();
        cycle(1'b1, 32'h1, 1'b0, 32'h0);
        m = 32'h1;
        flip_exp = '0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                flip_exp = m;
                cycle(1'b1, 32'h0, 1'b1, m ^ 32'h1);
            end else begin
                cycle(1'b1, 32'h0, 1'b1, m);
            end
            m = lfsr_step(m);
        end
        check("lfsr_flip_err_cnt", err_cnt1, 1);
        check("lfsr_flip_word_cnt", word_cnt1, 1000);
        check("lfsr_flip_fexp", fexp1, flip_exp);
        check("lfsr_flip_fact", fact1, flip_exp ^ 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
